// File: rtl/led_animator_if.sv
// Board-side bundle for led_animator: mode/step inputs from the switches,
// LED drive and frame pulse back out, plus the current position for observation.
interface led_animator_if #(
    parameter int N_LEDS = 8,
    parameter int STEP_W = 13
);
    localparam int POS_W = $clog2(2 * N_LEDS);

    // No handshake: mode and step_load are level inputs sampled every clock;
    // led_out and frame_done are registered levels/pulses valid after each edge.
    logic [1:0]        mode;
    logic [STEP_W-1:0] step_load;
    logic [N_LEDS-1:0] led_out;
    logic              frame_done;
    logic [POS_W-1:0]  dbg_pos;

    modport master (
        output mode,
        output step_load,
        input  led_out,
        input  frame_done,
        input  dbg_pos
    );

    modport slave (
        input  mode,
        input  step_load,
        output led_out,
        output frame_done,
        output dbg_pos
    );
endinterface

// File: rtl/led_animator.sv
// N-LED animator (dot, bar, bounce, breathing chase) driven by one step timer.
// Define LED_ANIM_BREATH_EN to build the PWM breathing mode; otherwise mode 3 acts as DOT.
module led_animator #(
    parameter int N_LEDS = 8,
    parameter int STEP_W = 13,
    parameter int PWM_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    led_animator_if.slave  bus
);
    localparam int POS_W = $clog2(2 * N_LEDS);
    localparam logic [POS_W-1:0] LAST_DOT = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] LAST_BAR = POS_W'(2 * N_LEDS - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    typedef enum logic [1:0] {
        MODE_DOT    = 2'd0,
        MODE_BAR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BREATH = 2'd3
    } mode_e;

    logic [1:0]        r_mode;
    logic [STEP_W-1:0] r_tcnt;
    logic [POS_W-1:0]  r_pos;
    logic              r_dir;
    logic              r_fd_pend;
    logic [N_LEDS-1:0] r_led;
    logic              r_frame_done;

    mode_e             w_anim;
    logic              w_restart;
    logic [STEP_W-1:0] w_last;
    logic              w_step;
    logic              w_wrap;
    logic [POS_W-1:0]  w_pos_nxt;
    logic              w_dir_nxt;
    logic [N_LEDS-1:0] w_pattern;

`ifdef LED_ANIM_BREATH_EN
    localparam logic [PWM_W-1:0] LVL_MAX = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] LVL_ONE = PWM_W'(1);
    logic [PWM_W-1:0] r_lvl;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [PWM_W-1:0] w_lvl_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pwm_cnt <= '0;
        else      r_pwm_cnt <= r_pwm_cnt + LVL_ONE;
    end

    assign w_anim = mode_e'(r_mode);
`else
    assign w_anim = (r_mode == MODE_BREATH) ? MODE_DOT : mode_e'(r_mode);
`endif

    assign w_restart = (bus.mode != r_mode);
    // Live compare: lowering step_load below the running count fires a step at once.
    assign w_last    = (bus.step_load == '0) ? '0 : bus.step_load - STEP_W'(1);
    assign w_step    = (r_tcnt >= w_last);

    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        w_wrap    = 1'b0;
`ifdef LED_ANIM_BREATH_EN
        w_lvl_nxt = r_lvl;
`endif
        case (w_anim)
            MODE_BAR: begin
                if (r_pos == LAST_BAR) begin
                    w_pos_nxt = '0;
                    w_wrap    = 1'b1;
                end else begin
                    w_pos_nxt = r_pos + POS_ONE;
                end
            end
            MODE_BOUNCE: begin
                // Reverse on arrival so each end LED is shown for a single step.
                if (!r_dir) begin
                    w_pos_nxt = r_pos + POS_ONE;
                    if (r_pos == LAST_DOT - POS_ONE) w_dir_nxt = 1'b1;
                end else begin
                    w_pos_nxt = r_pos - POS_ONE;
                    if (r_pos == POS_ONE) begin
                        w_dir_nxt = 1'b0;
                        w_wrap    = 1'b1;
                    end
                end
            end
`ifdef LED_ANIM_BREATH_EN
            MODE_BREATH: begin
                if (!r_dir) begin
                    w_lvl_nxt = r_lvl + LVL_ONE;
                    if (r_lvl == LVL_MAX - LVL_ONE) w_dir_nxt = 1'b1;
                end else begin
                    w_lvl_nxt = r_lvl - LVL_ONE;
                    if (r_lvl == LVL_ONE) begin
                        w_dir_nxt = 1'b0;
                        if (r_pos == LAST_DOT) begin
                            w_pos_nxt = '0;
                            w_wrap    = 1'b1;
                        end else begin
                            w_pos_nxt = r_pos + POS_ONE;
                        end
                    end
                end
            end
`endif
            default: begin
                if (r_pos == LAST_DOT) begin
                    w_pos_nxt = '0;
                    w_wrap    = 1'b1;
                end else begin
                    w_pos_nxt = r_pos + POS_ONE;
                end
            end
        endcase
    end

    always_comb begin
        w_pattern = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            case (w_anim)
                MODE_BAR: begin
                    if (int'(r_pos) < N_LEDS) w_pattern[i] = (i + int'(r_pos) >= N_LEDS - 1);
                    else                      w_pattern[i] = (i >= int'(r_pos) - N_LEDS + 1);
                end
`ifdef LED_ANIM_BREATH_EN
                MODE_BREATH: w_pattern[i] = (i == N_LEDS - 1 - int'(r_pos)) && (r_pwm_cnt < r_lvl);
`endif
                default:     w_pattern[i] = (i == N_LEDS - 1 - int'(r_pos));
            endcase
        end
    end

    // led_out and frame_done trail the step by one edge so they stay aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode       <= MODE_DOT;
            r_tcnt       <= '0;
            r_pos        <= '0;
            r_dir        <= 1'b0;
            r_fd_pend    <= 1'b0;
            r_led        <= '0;
            r_frame_done <= 1'b0;
`ifdef LED_ANIM_BREATH_EN
            r_lvl        <= '0;
`endif
        end else if (w_restart) begin
            r_mode       <= bus.mode;
            r_tcnt       <= '0;
            r_pos        <= '0;
            r_dir        <= 1'b0;
            r_fd_pend    <= 1'b0;
            r_led        <= '0;
            r_frame_done <= 1'b0;
`ifdef LED_ANIM_BREATH_EN
            r_lvl        <= '0;
`endif
        end else begin
            r_led        <= w_pattern;
            r_frame_done <= r_fd_pend;
            r_fd_pend    <= w_step & w_wrap;
            if (w_step) begin
                r_tcnt <= '0;
                r_pos  <= w_pos_nxt;
                r_dir  <= w_dir_nxt;
`ifdef LED_ANIM_BREATH_EN
                r_lvl  <= w_lvl_nxt;
`endif
            end else begin
                r_tcnt <= r_tcnt + STEP_W'(1);
            end
        end
    end

    assign bus.led_out    = r_led;
    assign bus.frame_done = r_frame_done;
    assign bus.dbg_pos    = r_pos;

endmodule

// File: tb/tb_led_animator.sv
// Directed bench for led_animator (N_LEDS=8, STEP_W=13, PWM_W=4) with hand-built pattern tables.
module tb_led_animator;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [7:0] dot_tab [0:7];
  logic [7:0] bar_tab [0:15];
  logic [7:0] bnc_tab [0:13];

  always #5 clk = ~clk;

  led_animator_if #(.N_LEDS(8), .STEP_W(13)) bus ();

  led_animator #(.N_LEDS(8), .STEP_W(13), .PWM_W(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp_led, input logic exp_fd);
    chk({tag, "_led"}, 32'(bus.led_out), 32'(exp_led));
    chk({tag, "_fd"}, 32'(bus.frame_done), 32'(exp_fd));
  endtask

  initial begin
    int hi_cnt;
    logic [7:0] other_acc;
    logic fd_acc;

    dot_tab = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    bar_tab = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    bnc_tab = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02,
                8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

    // Reset and DOT, step every 3 cycles
    rst_n = 1'b0;
    bus.mode = 2'd0;
    bus.step_load = 13'd3;
    tick();
    tick();
    chk_out("rst", 8'h00, 1'b0);
    chk("rst_pos", 32'(bus.dbg_pos), 32'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      tick();
      chk_out($sformatf("dot%0d", e), dot_tab[((e - 1) / 3) % 8], (e == 25));
    end

    // Switch to BAR while tcnt == L-1 and DOT shows 10: the pending step is dropped
    bus.mode = 2'd1;
    tick();
    chk_out("chg_blank", 8'h00, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk_out($sformatf("chg_hold%0d", e), 8'h80, 1'b0);
    end
    tick();
    chk_out("chg_next", 8'hC0, 1'b0);

    // BOUNCE, step every 2 cycles
    bus.mode = 2'd2;
    bus.step_load = 13'd2;
    tick();
    chk_out("bnc_blank", 8'h00, 1'b0);
    for (int e = 1; e <= 30; e++) begin
      tick();
      chk_out($sformatf("bnc%0d", e), bnc_tab[((e - 1) / 2) % 14], (e == 29));
    end

    // BAR, step every cycle
    bus.mode = 2'd1;
    bus.step_load = 13'd1;
    tick();
    chk_out("bar_blank", 8'h00, 1'b0);
    for (int e = 1; e <= 18; e++) begin
      tick();
      chk_out($sformatf("bar%0d", e), bar_tab[(e - 1) % 16], (e == 17));
    end

    // Mode 3, step every 4 cycles
    bus.mode = 2'd3;
    bus.step_load = 13'd4;
    tick();
    chk_out("m3_blank", 8'h00, 1'b0);
`ifdef LED_ANIM_BREATH_EN
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e <= 4) chk_out($sformatf("brt_dark%0d", e), 8'h00, 1'b0);
    end
    // lvl is now 5; stretch the step so it holds for the duty measurement
    bus.step_load = 13'd8191;
    tick();
    hi_cnt = 0;
    other_acc = 8'h00;
    fd_acc = 1'b0;
    for (int e = 0; e < 32; e++) begin
      tick();
      if (bus.led_out[7]) hi_cnt++;
      other_acc = other_acc | (bus.led_out & 8'h7F);
      fd_acc = fd_acc | bus.frame_done;
    end
    chk("brt_duty", 32'(hi_cnt), 32'd10);
    chk("brt_others", 32'(other_acc), 32'd0);
    chk("brt_fd", 32'(fd_acc), 32'd0);
`else
    for (int e = 1; e <= 33; e++) begin
      tick();
      chk_out($sformatf("m3dot%0d", e), dot_tab[((e - 1) / 4) % 8], (e == 33));
    end
`endif

    // Async reset in the middle of BOUNCE
    bus.mode = 2'd2;
    bus.step_load = 13'd1;
    tick();
    chk_out("ar_blank", 8'h00, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk_out($sformatf("ar_bnc%0d", e), bnc_tab[e - 1], 1'b0);
    end
    rst_n = 1'b0;
    #1;
    chk_out("ar_async", 8'h00, 1'b0);
    bus.mode = 2'd0;
    bus.step_load = 13'd0;
    tick();
    tick();
    chk_out("ar_held", 8'h00, 1'b0);
    rst_n = 1'b1;

    // step_load=0 steps every cycle, then step_load=1 keeps the same cadence
    for (int e = 1; e <= 18; e++) begin
      if (e == 11) bus.step_load = 13'd1;
      tick();
      chk_out($sformatf("l0dot%0d", e), dot_tab[(e - 1) % 8], (e == 9) || (e == 17));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
